serial_word_feeder: RTL
=======================

# serial_word_feeder

Parallel-to-serial front end for the 1010 sequence-detector path: accepts WIDTH-bit words over a valid/ready handshake and emits them one bit per clock on a single serial line that drives the detector's `data_in`. A one-word holding buffer lets a producer stream words with no bubble between consecutive words on the serial line. The block sits directly upstream of the detector in the same clock domain.

## Interface
- WIDTH, 8, bits per word (≥2).
- MSB_FIRST, 1, 1 = bit WIDTH-1 is sent first; 0 = bit 0 is sent first.
- IDLE_BIT, 0, level driven on `data_out` when no word is being sent.

- clk  in  1  rising-edge clock, the only clock.
- rst  in  1  reset, synchronous, active-low (asserted when 0, sampled on rising `clk`).
- word_in  in  WIDTH  parallel word from the producer.
- word_valid  in  1  producer has a word on `word_in`.
- word_ready  out  1  block can accept a word this cycle.
- data_out  out  1  serial bit to the detector `data_in`.
- bit_valid  out  1  `data_out` carries a real data bit this cycle.
- last_bit  out  1  `data_out` carries the final bit of a word.
- busy  out  1  shifter active or holding buffer occupied.

## Operation
- Storage: shifter (WIDTH bits), bit counter (0..WIDTH-1), holding register plus `hold_full` flag.
- Handshake: a word transfers on a rising edge where `word_valid` and `word_ready` are both 1. `word_ready` = NOT `hold_full` (registered, with no combinational path from `word_valid`).
- The producer must keep `word_in` stable while `word_valid` is 1 and `word_ready` is 0. Each transferred word is sent exactly once.
- States:
  - IDLE: `bit_valid`=0 and `data_out`=IDLE_BIT.
  - On a transfer, the word loads straight into the shifter, the counter is set to 0, and the state goes to SHIFT.
- SHIFT, each edge:
  - If the counter is below WIDTH-1, shift one position and increment the counter.
  - If the counter equals WIDTH-1 (last bit), then:
    - if `hold_full`, load the shifter from hold, clear `hold_full`, counter to 0, stay in SHIFT;
    - else if a transfer occurs on this edge, load `word_in` directly (bypass), counter to 0, stay in SHIFT;
    - else go to IDLE.
- A transfer during SHIFT, other than the bypass case, writes the holding register and sets `hold_full`.
- A transfer and a hold drain never occur on the same edge, because `word_ready`=0 whenever `hold_full`=1.
- Bit order:
  - MSB_FIRST=1: `data_out` = shifter[WIDTH-1], shift left.
  - MSB_FIRST=0: `data_out` = shifter[0], shift right.
  - Bits shifted in carry IDLE_BIT.
- `bit_valid`=1 exactly in SHIFT. `last_bit` = `bit_valid` AND counter==WIDTH-1.
- `busy` = (state==SHIFT) OR `hold_full`.

## Timing
- All outputs are registered or decoded from registers only; no input-to-output combinational path.
- Reset (`rst`=0 at an edge): state IDLE, counter 0, `hold_full`=0, shifter=IDLE_BIT fill. After that edge: `word_ready`=1, `data_out`=IDLE_BIT, `bit_valid`=0, `last_bit`=0, `busy`=0.
- Reset takes priority over every other event, including a simultaneous transfer.
- Latency: a word transferred at edge N puts bit k on `data_out` in the cycle after edge N+k, for k=0..WIDTH-1.
- Throughput: with the producer always valid, one bit per cycle continuously and zero idle cycles between words. Steady-state `word_ready` duty is 1 cycle per WIDTH.
- A reset during SHIFT with `hold_full`=1 discards both the in-flight word and the held word. `data_out` returns to IDLE_BIT after the reset edge, with no partial bits emitted.
- After the last bit with nothing pending, IDLE is entered on the next edge and `data_out`=IDLE_BIT from then on.

## Test plan
- Single word, WIDTH=4, MSB_FIRST=1: transfer 4'b1010 at edge N → `data_out` 1,0,1,0 in cycles N+1..N+4, `bit_valid` high for exactly 4 cycles, `last_bit` high only in N+4, downstream detector output pulses once.
- Back-to-back: `word_valid` held high with 4'hA then 4'hA → 8 contiguous bits 1,0,1,0,1,0,1,0 with `bit_valid` unbroken; `word_ready` low from the second transfer until the hold drains.
- Bypass at last bit: single 4'hC in flight, second word 4'h3 offered only at the edge where counter=3 → `data_out` 1,1,0,0,0,0,1,1 with no gap, and `hold_full` never set.
- LSB first, MSB_FIRST=0, WIDTH=4: transfer 4'b0011 → `data_out` 1,1,0,0.
- Stall: `word_valid` held with 4'h5 while `word_ready`=0 for 3 cycles → word is accepted exactly once and sent once.
- Reset mid-word: assert `rst`=0 after bit 1 of 4'hA with a held word → next cycle `data_out`=IDLE_BIT, `bit_valid`=0, `busy`=0, `word_ready`=1; after release the held word is never emitted.

Source files
------------

// File: rtl/serial_word_feeder.sv
// Parallel-to-serial front end for the 1010 detector: takes WIDTH-bit words over valid/ready
// and emits them one bit per clock. A one-word holding buffer lets back-to-back words stream gap-free.
module serial_word_feeder #(
  parameter int   WIDTH     = 8,
  parameter int   MSB_FIRST = 1,
  parameter logic IDLE_BIT  = 1'b0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] word_in,
  input  logic             word_valid,
  output logic             word_ready,
  output logic             data_out,
  output logic             bit_valid,
  output logic             last_bit,
  output logic             busy
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST_CNT = CW'(WIDTH - 1);
  localparam logic [WIDTH-1:0] FILL = {WIDTH{IDLE_BIT}};

  typedef enum logic {IDLE, SHIFT} state_t;

  state_t           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] shift_q, shift_d;
  logic [WIDTH-1:0] hold_q, hold_d;
  logic             holdFull_q, holdFull_d;

  logic             xfer;
  logic             atLast;
  logic [WIDTH-1:0] shifted;

  assign word_ready = ~holdFull_q;
  assign xfer       = word_valid & ~holdFull_q;
  assign atLast     = (cnt_q == LAST_CNT);
  assign shifted    = (MSB_FIRST != 0) ? {shift_q[WIDTH-2:0], IDLE_BIT}
                                       : {IDLE_BIT, shift_q[WIDTH-1:1]};

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      shift_q    <= FILL;
      hold_q     <= FILL;
      holdFull_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      shift_q    <= shift_d;
      hold_q     <= hold_d;
      holdFull_q <= holdFull_d;
    end
  end

  // On the last bit, a pending held word wins over a bypass; word_ready is low then anyway.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    shift_d    = shift_q;
    hold_d     = hold_q;
    holdFull_d = holdFull_q;
    unique case (state_q)
      IDLE: begin
        if (xfer) begin
          shift_d = word_in;
          cnt_d   = '0;
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        if (!atLast) begin
          shift_d = shifted;
          cnt_d   = cnt_q + 1'b1;
          if (xfer) begin
            hold_d     = word_in;
            holdFull_d = 1'b1;
          end
        end else if (holdFull_q) begin
          shift_d    = hold_q;
          holdFull_d = 1'b0;
          cnt_d      = '0;
        end else if (xfer) begin
          shift_d = word_in;
          cnt_d   = '0;
        end else begin
          shift_d = FILL;
          cnt_d   = '0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign bit_valid = (state_q == SHIFT);
  assign last_bit  = bit_valid & atLast;
  assign busy      = bit_valid | holdFull_q;
  assign data_out  = bit_valid ? ((MSB_FIRST != 0) ? shift_q[WIDTH-1] : shift_q[0]) : IDLE_BIT;

endmodule
